traffic_phase_sched: RTL and testbench

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/traffic_phase_sched_timer.sv | 38 +++
 rtl/traffic_phase_sched.sv | 133 +++++++++++++
 tb/tb_traffic_phase_sched.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light encodings, FSM state codes and the lamp decode for the
// two-road intersection scheduler.
package traffic_pkg;

  localparam logic [1:0] GREEN  = 2'b11;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b00;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    RED_A = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    RED_B = 3'd5,
    WALK  = 3'd6
  } state_e;

  typedef enum logic {
    ROAD_A = 1'b0,
    ROAD_B = 1'b1
  } road_e;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
    logic       walk;
  } lamps_t;

  function automatic lamps_t decode_lamps(input state_e s);
    lamps_t l;
    l = '{la: RED, lb: RED, walk: 1'b0};
    case (s)
      A_GRN:   l.la   = GREEN;
      A_YEL:   l.la   = YELLOW;
      B_GRN:   l.lb   = GREEN;
      B_YEL:   l.lb   = YELLOW;
      WALK:    l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_sched_timer.sv
// Per-state cycle counter: clears when the state changes, saturates at a
// programmable limit and flags the last cycle of a len-cycle interval.
module phase_timer #(
  parameter int unsigned TW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic [TW-1:0] limit_i,
  input  logic [TW-1:0] len_i,
  output logic [TW-1:0] cnt_o,
  output logic          tc_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q < limit_i) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == (len_i - TW'(1)));

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road traffic light scheduler with min/max green, yellow, all-red
// clearance and a pedestrian walk phase inserted after a clearance.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 32,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALL_RED_T = 1,
  parameter int unsigned WALK_T    = 6,
  parameter int unsigned TW        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped_req,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  state_e        state_q, state_d;
  logic          ped_pending_q, ped_pending_d;
  road_e         last_road_q, last_road_d;
  logic [1:0]    la_q, lb_q;
  logic          walk_q, ped_ack_q;
  logic [TW-1:0] timer;
  logic          tc;
  logic [TW-1:0] len;
  logic [TW-1:0] limit;
  logic          state_chg;
  logic          min_done;
  logic          ped_any;
  lamps_t        lamps_d;

  // Green states use MAX_GREEN as the interval so tc doubles as "max reached".
  always_comb begin
    len   = TW'(MAX_GREEN);
    limit = '1;
    case (state_q)
      A_GRN, B_GRN: begin
        len   = TW'(MAX_GREEN);
        limit = TW'(MAX_GREEN - 1);
      end
      A_YEL, B_YEL: len = TW'(YELLOW_T);
      RED_A, RED_B: len = TW'(ALL_RED_T);
      WALK:         len = TW'(WALK_T);
      default:      len = TW'(MAX_GREEN);
    endcase
  end

  assign min_done = (timer >= TW'(MIN_GREEN - 1));
  assign ped_any  = ped_pending_q | ped_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      A_GRN: if (min_done && (tb || ped_any) && (!ta || tc)) state_d = A_YEL;
      A_YEL: if (tc) state_d = RED_A;
      RED_A: if (tc) state_d = ped_any ? WALK : B_GRN;
      B_GRN: if (min_done && (ta || ped_any) && (!tb || tc)) state_d = B_YEL;
      B_YEL: if (tc) state_d = RED_B;
      RED_B: if (tc) state_d = ped_any ? WALK : A_GRN;
      WALK:  if (tc) state_d = (last_road_q == ROAD_A) ? B_GRN : A_GRN;
      default: state_d = A_GRN;
    endcase
  end

  assign state_chg = (state_d != state_q);

  // Entering WALK clears the request even if ped_req is high that same cycle.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (state_d == WALK && state_q != WALK) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && state_q != WALK) begin
      ped_pending_d = 1'b1;
    end
  end

  always_comb begin
    last_road_d = last_road_q;
    if (state_q == A_GRN && state_chg) begin
      last_road_d = ROAD_A;
    end else if (state_q == B_GRN && state_chg) begin
      last_road_d = ROAD_B;
    end
  end

  assign lamps_d = decode_lamps(state_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= A_GRN;
      ped_pending_q <= 1'b0;
      last_road_q   <= ROAD_B;
      la_q          <= GREEN;
      lb_q          <= RED;
      walk_q        <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      last_road_q   <= last_road_d;
      la_q          <= lamps_d.la;
      lb_q          <= lamps_d.lb;
      walk_q        <= lamps_d.walk;
      ped_ack_q     <= (state_d == WALK) && (state_q != WALK);
    end
  end

  phase_timer #(
    .TW(TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_chg),
    .limit_i(limit),
    .len_i  (len),
    .cnt_o  (timer),
    .tc_o   (tc)
  );

  assign la      = la_q;
  assign lb      = lb_q;
  assign walk    = walk_q;
  assign ped_ack = ped_ack_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench: directed timelines push expected lamps per cycle, a
// negedge monitor pops and compares them and checks light exclusivity.
module tb_traffic_phase_sched;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ta = 1'b0, tb = 1'b0, ped_req = 1'b0;
  logic [1:0] la, lb;
  logic       walk, ped_ack;
  logic [2:0] phase;

  traffic_phase_sched #(
    .MIN_GREEN(8),
    .MAX_GREEN(32),
    .YELLOW_T (3),
    .ALL_RED_T(1),
    .WALK_T   (6),
    .TW       (6)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ta     (ta),
    .tb     (tb),
    .ped_req(ped_req),
    .la     (la),
    .lb     (lb),
    .walk   (walk),
    .ped_ack(ped_ack),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [1:0]  la;
    logic [1:0]  lb;
    logic        walk;
    logic        ack;
    logic [2:0]  ph;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
      e = sbq.pop_front();
      checks++;
      if (e.cyc != cyc_cnt || la !== e.la || lb !== e.lb || walk !== e.walk ||
          ped_ack !== e.ack || phase !== e.ph) begin
        failures++;
        $display("FAIL %s cyc=%0d got la=%b lb=%b walk=%b ack=%b phase=%0d exp la=%b lb=%b walk=%b ack=%b phase=%0d",
                 e.name, e.cyc, la, lb, walk, ped_ack, phase, e.la, e.lb, e.walk, e.ack, e.ph);
      end
    end
    checks++;
    if ((la !== RED && lb !== RED) || (walk === 1'b1 && (la !== RED || lb !== RED)) ||
        (ped_ack === 1'b1 && walk !== 1'b1)) begin
      failures++;
      $display("FAIL exclusivity cyc=%0d got la=%b lb=%b walk=%b ack=%b exp at most one non-red, walk only all-red",
               cyc_cnt, la, lb, walk, ped_ack);
    end
  end

  task automatic cyc(input bit a, input bit b, input bit p, input string nm,
                     input state_e s, input bit ack);
    exp_t e;
    ta = a; tb = b; ped_req = p;
    e.cyc = cyc_cnt; e.name = nm; e.ack = ack; e.ph = s;
    e.la = RED; e.lb = RED; e.walk = 1'b0;
    case (s)
      A_GRN: e.la = 2'b11;
      A_YEL: e.la = 2'b01;
      B_GRN: e.lb = 2'b11;
      B_YEL: e.lb = 2'b01;
      WALK:  e.walk = 1'b1;
      default: ;
    endcase
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic state_e maxg(input int unsigned c);
    int unsigned m;
    m = c % 72;
    if (m < 32) return A_GRN;
    if (m < 35) return A_YEL;
    if (m == 35) return RED_A;
    if (m < 68) return B_GRN;
    if (m < 71) return B_YEL;
    return RED_B;
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d got no finish exp finish", cyc_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    state_e s;
    @(posedge clk); #1;

    ta = 1'b1; tb = 1'b0; do_reset();
    for (int unsigned c = 0; c < 100; c++) cyc(1, 0, 0, "rest", A_GRN, 0);

    ta = 1'b0; tb = 1'b1; do_reset();
    for (int unsigned c = 0; c < 20; c++) begin
      s = (c < 8) ? A_GRN : (c < 11) ? A_YEL : (c == 11) ? RED_A : B_GRN;
      cyc(0, 1, 0, "min_green", s, 0);
    end

    ta = 1'b1; tb = 1'b1; do_reset();
    for (int unsigned c = 0; c < 150; c++) cyc(1, 1, 0, "max_green", maxg(c), 0);

    ta = 1'b0; tb = 1'b0; do_reset();
    for (int unsigned c = 0; c < 31; c++) begin
      s = (c < 8) ? A_GRN : (c < 11) ? A_YEL : (c == 11) ? RED_A : (c < 18) ? WALK : B_GRN;
      cyc(0, 0, (c == 2 || c == 14), "ped", s, (c == 12));
    end

    // Pending request raised at cycle 40 must not survive the reset at 69.
    ta = 1'b1; tb = 1'b1; do_reset();
    for (int unsigned c = 0; c < 70; c++) begin
      if (c == 69) rst = 1'b1;
      cyc(1, 1, (c == 40), "pre_reset", maxg(c), 0);
    end
    rst = 1'b0;
    for (int unsigned c = 0; c < 40; c++) cyc(1, 0, 0, "post_reset", A_GRN, 0);

    do_reset();
    for (int unsigned c = 0; c < 10000; c++) begin
      ta = 1'($urandom_range(0, 1));
      tb = 1'($urandom_range(0, 1));
      ped_req = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end

    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
